// File: rtl/pingpong_frame_buffer_if.sv
// Bus bundle for the ping-pong frame buffer: sample input handshake,
// frame presentation/release, read port and drop statistics.
interface pingpong_frame_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int MAX_FRAME  = 256,
  parameter int CNT_WIDTH  = 16
) ();
  localparam int LW  = $clog2(MAX_FRAME);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                         flush;
  logic [LW:0]                  frame_len;
  logic                         valid_in;
  logic [NUM_CH*DATA_WIDTH-1:0] sample_in;
  logic                         in_ready;
  logic                         frame_valid;
  logic                         frame_bank;
  logic [LW:0]                  frame_len_out;
  logic                         frame_done;
  logic                         rd_en;
  logic [LW-1:0]                rd_addr;
  logic [CHW-1:0]               rd_ch;
  logic [DATA_WIDTH-1:0]        rd_data;
  logic                         rd_valid;
  logic                         overflow;
  logic [CNT_WIDTH-1:0]         drop_count;

  // Producer/consumer side that drives samples and reads frames.
  modport master (
    output flush, frame_len, valid_in, sample_in, frame_done, rd_en, rd_addr, rd_ch,
    input  in_ready, frame_valid, frame_bank, frame_len_out, rd_data, rd_valid,
           overflow, drop_count
  );

  // Buffer side.
  modport slave (
    input  flush, frame_len, valid_in, sample_in, frame_done, rd_en, rd_addr, rd_ch,
    output in_ready, frame_valid, frame_bank, frame_len_out, rd_data, rd_valid,
           overflow, drop_count
  );
endinterface

// File: rtl/pingpong_frame_buffer.sv
// Two-bank ping-pong frame buffer. Beats of NUM_CH parallel samples are
// written into one bank while the other, once complete, is served through a
// registered read port. Both banks full stalls the input; dropped beats are
// counted with a saturating counter.
module pingpong_frame_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int MAX_FRAME  = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic clk,
  input  logic reset,
  pingpong_frame_buffer_if.slave bus
);
  localparam int LW  = $clog2(MAX_FRAME);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WW  = NUM_CH * DATA_WIDTH;

  logic [1:0]           full;
  logic [LW:0]          len [2];
  logic                 wr_bank;
  logic                 rd_bank;
  logic [LW-1:0]        wr_ptr;
  logic                 overflow_q;
  logic [CNT_WIDTH-1:0] drop_count_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                 rd_valid_q;

  logic [WW-1:0]        mem [2*MAX_FRAME];

  logic                 in_ready;
  logic [LW:0]          eff_len;
  logic [LW:0]          cur_len;
  logic                 accept;
  logic                 drop;
  logic                 last_beat;
  logic                 release_frame;
  logic [WW-1:0]        rd_word;
  logic [DATA_WIDTH-1:0] rd_lane;
  logic                 rd_hit;

  assign in_ready          = !full[wr_bank];
  assign bus.in_ready      = in_ready;
  assign bus.frame_valid   = full[rd_bank];
  assign bus.frame_bank    = rd_bank;
  assign bus.frame_len_out = len[rd_bank];
  assign bus.overflow      = overflow_q;
  assign bus.drop_count    = drop_count_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;

  // Decode the write-side events: clamped length, beat accept/drop, frame end.
  always_comb begin
    eff_len = bus.frame_len;
    if (bus.frame_len == '0 || bus.frame_len > (LW+1)'(MAX_FRAME))
      eff_len = (LW+1)'(MAX_FRAME);
    cur_len       = (wr_ptr == '0) ? eff_len : len[wr_bank];
    accept        = bus.valid_in && in_ready;
    drop          = bus.valid_in && !in_ready;
    last_beat     = ({1'b0, wr_ptr} == (cur_len - 1'b1));
    release_frame = bus.frame_done && full[rd_bank];
  end

  // Read lookup: fetch the addressed beat of the presented bank and pick a lane.
  always_comb begin
    rd_word = mem[{rd_bank, bus.rd_addr}];
    rd_lane = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.rd_ch == CHW'(k))
        rd_lane = rd_word[k*DATA_WIDTH +: DATA_WIDTH];
    end
    rd_hit = full[rd_bank] && ({1'b0, bus.rd_addr} < len[rd_bank]) &&
             (32'(bus.rd_ch) < NUM_CH);
  end

  // Bank bookkeeping: fill/release the banks, flush, and drop statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full         <= '0;
      len[0]       <= '0;
      len[1]       <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_ptr       <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != '1)
          drop_count_q <= drop_count_q + 1'b1;
      end
      if (bus.flush) begin
        full    <= '0;
        wr_ptr  <= '0;
        wr_bank <= 1'b0;
        rd_bank <= 1'b0;
      end else begin
        if (accept) begin
          if (wr_ptr == '0)
            len[wr_bank] <= eff_len;
          if (last_beat) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
            wr_ptr        <= '0;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
          end
        end
        if (release_frame) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

  // Sample storage; contents survive flush, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (accept && !bus.flush)
      mem[{wr_bank, wr_ptr}] <= bus.sample_in;
  end

  // Registered read port: one cycle after rd_en, zero for invalid requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en)
        rd_data_q <= rd_hit ? rd_lane : '0;
    end
  end
endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Self-checking bench for pingpong_frame_buffer: directed scenarios plus a
// randomized phase, compared against a frame-queue reference model.
module tb_pingpong_frame_buffer;
  localparam int DW   = 16;
  localparam int NCH  = 2;
  localparam int MAXF = 256;
  localparam int CW   = 16;

  logic clk;
  logic reset;

  pingpong_frame_buffer_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_FRAME(MAXF), .CNT_WIDTH(CW)) bus ();

  pingpong_frame_buffer #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_FRAME(MAXF), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference model: a queue of completed frames (front = presented one)
  // plus the frame currently being assembled.
  int          q_bank[$];
  int          q_len[$];
  logic [31:0] mdata [2][MAXF];
  logic [31:0] part_data [MAXF];
  int          part_cnt;
  int          part_len;
  int          next_bank;
  int          bank_len [2];
  bit          m_ovf;
  int          m_drops;

  task automatic check_output(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input int fl);
    return (fl == 0 || fl > MAXF) ? MAXF : fl;
  endfunction

  task automatic model_reset();
    q_bank.delete();
    q_len.delete();
    part_cnt    = 0;
    part_len    = 0;
    next_bank   = 0;
    bank_len[0] = 0;
    bank_len[1] = 0;
    m_ovf       = 0;
    m_drops     = 0;
  endtask

  // One clock: check presented state, advance the model, check registered outputs.
  task automatic cycle();
    bit          ready;
    bit          exp_rv;
    int          exp_rd;
    logic [31:0] w;
    ready = (q_bank.size() < 2);
    check_output("in_ready", bus.in_ready, ready);
    check_output("frame_valid", bus.frame_valid, q_bank.size() > 0);
    check_output("frame_bank", bus.frame_bank, (q_bank.size() > 0) ? q_bank[0] : next_bank);
    check_output("frame_len_out", bus.frame_len_out,
                 (q_bank.size() > 0) ? q_len[0] : bank_len[next_bank]);

    exp_rv = bus.rd_en;
    exp_rd = 0;
    if (q_bank.size() > 0 && int'(bus.rd_addr) < q_len[0] && int'(bus.rd_ch) < NCH) begin
      w = mdata[q_bank[0]][bus.rd_addr];
      exp_rd = int'((w >> (DW * int'(bus.rd_ch))) & 32'h0000_ffff);
    end

    if (bus.valid_in && !ready) begin
      m_ovf = 1;
      if (m_drops < 65535) m_drops++;
    end
    if (bus.flush) begin
      q_bank.delete();
      q_len.delete();
      part_cnt  = 0;
      next_bank = 0;
    end else begin
      if (bus.frame_done && q_bank.size() > 0) begin
        void'(q_bank.pop_front());
        void'(q_len.pop_front());
      end
      if (bus.valid_in && ready) begin
        if (part_cnt == 0) begin
          part_len = eff_len(int'(bus.frame_len));
          bank_len[next_bank] = part_len;
        end
        part_data[part_cnt] = bus.sample_in;
        part_cnt++;
        if (part_cnt == part_len) begin
          for (int j = 0; j < part_len; j++) mdata[next_bank][j] = part_data[j];
          q_bank.push_back(next_bank);
          q_len.push_back(part_len);
          next_bank = 1 - next_bank;
          part_cnt  = 0;
        end
      end
    end

    @(posedge clk);
    #1;
    check_output("rd_valid", bus.rd_valid, exp_rv);
    if (exp_rv) check_output("rd_data", bus.rd_data, exp_rd);
    check_output("overflow", bus.overflow, m_ovf);
    check_output("drop_count", bus.drop_count, m_drops);
  endtask

  task automatic apply_stimulus(input bit v, input logic [31:0] s, input bit fd,
                                input bit re, input int addr, input int ch, input bit fl);
    bus.valid_in   = v;
    bus.sample_in  = s;
    bus.frame_done = fd;
    bus.rd_en      = re;
    bus.rd_addr    = 8'(addr);
    bus.rd_ch      = 1'(ch);
    bus.flush      = fl;
    cycle();
  endtask

  task automatic idle();
    apply_stimulus(0, 32'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic beat(input int i, input bit fd);
    apply_stimulus(1, {16'(i + 100), 16'(i)}, fd, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    bus.valid_in   = 0;
    bus.frame_done = 0;
    bus.rd_en      = 0;
    bus.flush      = 0;
    #2 reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.frame_len = 9'd4;
    bus.sample_in = '0;
    bus.rd_addr   = '0;
    bus.rd_ch     = '0;
    do_reset();

    check_output("reset_in_ready", bus.in_ready, 1);
    check_output("reset_frame_valid", bus.frame_valid, 0);
    check_output("reset_len_out", bus.frame_len_out, 0);
    check_output("reset_rd_data", bus.rd_data, 0);
    idle();

    // Basic 4-beat frame and a lane read.
    for (int i = 0; i < 4; i++) beat(i, 0);
    check_output("t1_frame_valid", bus.frame_valid, 1);
    check_output("t1_frame_bank", bus.frame_bank, 0);
    check_output("t1_len_out", bus.frame_len_out, 4);
    apply_stimulus(0, 32'h0, 0, 1, 2, 1, 0);
    check_output("t1_rd_data", bus.rd_data, 102);
    apply_stimulus(0, 32'h0, 1, 0, 0, 0, 0);

    // Both banks full, three drops, then a release.
    do_reset();
    for (int i = 0; i < 8; i++) beat(i, 0);
    for (int i = 0; i < 3; i++) beat(50 + i, 0);
    check_output("t2_in_ready", bus.in_ready, 0);
    check_output("t2_overflow", bus.overflow, 1);
    check_output("t2_drops", bus.drop_count, 3);
    apply_stimulus(0, 32'h0, 1, 0, 0, 0, 0);
    check_output("t2_bank_after", bus.frame_bank, 1);
    check_output("t2_ready_after", bus.in_ready, 1);
    apply_stimulus(0, 32'h0, 0, 1, 3, 0, 0);
    check_output("t2_rd_bank1", bus.rd_data, 7);

    // Last beat of bank1 together with release of bank0.
    do_reset();
    for (int i = 0; i < 7; i++) beat(i, 0);
    beat(7, 1);
    check_output("t3_frame_valid", bus.frame_valid, 1);
    check_output("t3_frame_bank", bus.frame_bank, 1);
    check_output("t3_in_ready", bus.in_ready, 1);

    // frame_len=0 gives a full-size frame; length changes take effect next frame.
    do_reset();
    bus.frame_len = 9'd0;
    for (int i = 0; i < MAXF - 1; i++) beat(i, 0);
    check_output("t4_not_yet", bus.frame_valid, 0);
    beat(MAXF - 1, 0);
    check_output("t4_full_len", bus.frame_len_out, MAXF);
    apply_stimulus(0, 32'h0, 1, 0, 0, 0, 0);
    bus.frame_len = 9'd8;
    for (int i = 0; i < 5; i++) beat(i, 0);
    bus.frame_len = 9'd3;
    for (int i = 5; i < 8; i++) beat(i, 0);
    check_output("t4_len8", bus.frame_len_out, 8);
    for (int i = 0; i < 3; i++) beat(i, 0);
    apply_stimulus(0, 32'h0, 1, 0, 0, 0, 0);
    check_output("t4_len3", bus.frame_len_out, 3);
    check_output("t4_len3_valid", bus.frame_valid, 1);

    // Out-of-range read and release of an absent frame.
    do_reset();
    bus.frame_len = 9'd4;
    for (int i = 0; i < 4; i++) beat(i, 0);
    apply_stimulus(0, 32'h0, 0, 1, 6, 1, 0);
    check_output("t5_rd_valid", bus.rd_valid, 1);
    check_output("t5_rd_zero", bus.rd_data, 0);
    apply_stimulus(0, 32'h0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 32'h0, 1, 0, 0, 0, 0);
    check_output("t5_bank_held", bus.frame_bank, 1);

    // Flush mid-frame keeps drop statistics.
    do_reset();
    for (int i = 0; i < 8; i++) beat(i, 0);
    beat(90, 0);
    beat(91, 0);
    apply_stimulus(0, 32'h0, 1, 0, 0, 0, 0);
    beat(20, 0);
    beat(21, 0);
    apply_stimulus(0, 32'h0, 0, 0, 0, 0, 1);
    check_output("t6_flush_ready", bus.in_ready, 1);
    check_output("t6_flush_fv", bus.frame_valid, 0);
    check_output("t6_flush_drops", bus.drop_count, 2);
    for (int i = 0; i < 4; i++) beat(30 + i, 0);
    check_output("t6_new_frame", bus.frame_valid, 1);
    apply_stimulus(0, 32'h0, 0, 1, 1, 1, 0);
    check_output("t6_rd", bus.rd_data, 131);

    // Reset mid-frame behaves as power-up.
    apply_stimulus(0, 32'h0, 1, 0, 0, 0, 0);
    beat(40, 0);
    beat(41, 0);
    do_reset();
    check_output("t6_reset_ready", bus.in_ready, 1);
    check_output("t6_reset_fv", bus.frame_valid, 0);
    for (int i = 0; i < 4; i++) beat(60 + i, 0);
    check_output("t6_reset_frame", bus.frame_valid, 1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 39);
      if (r == 0)      bus.frame_len = 9'd0;
      else if (r == 1) bus.frame_len = 9'd300;
      else if (r < 8)  bus.frame_len = 9'($urandom_range(1, 6));
      apply_stimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 1),
                     $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
